// File: rtl/loop_detector.sv
// Loop detector: a fully-associative table that learns backward-branch trip counts and overrides fetch predictions for LOCKED loops.
// Define LD_CONFIRM_EN to require two equal consecutive trips before locking; otherwise TRAIN locks directly.
module loop_detector #(
    parameter int ENTRIES = 4,
    parameter int CNT_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_F,
    input  logic        branch_en_F,
    input  logic        backward_F,
    input  logic        stall_F,
    input  logic [31:0] PC_EX,
    input  logic        branch_en_EX,
    input  logic        backward_EX,
    input  logic        branch_result,
    input  logic        branch_correction,
    output logic        LD_hit_F,
    output logic        LD_decision_F
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {
        TRAIN   = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // State entered when a trip count is (re)learned.
`ifdef LD_CONFIRM_EN
    localparam state_t RETRAIN = CONFIRM;
`else
    localparam state_t RETRAIN = LOCKED;
`endif

    logic [ENTRIES-1:0] r_valid;
    logic [11:0]        r_tag   [ENTRIES];
    state_t             r_state [ENTRIES];
    logic [CNT_W-1:0]   r_trip  [ENTRIES];
    logic [CNT_W-1:0]   r_cur   [ENTRIES];
    logic [CNT_W-1:0]   r_spec  [ENTRIES];
    logic [IDX_W-1:0]   r_ptr;

    logic [ENTRIES-1:0] w_valid_n;
    logic [11:0]        w_tag_n   [ENTRIES];
    state_t             w_state_n [ENTRIES];
    logic [CNT_W-1:0]   w_trip_n  [ENTRIES];
    logic [CNT_W-1:0]   w_cur_n   [ENTRIES];
    logic [CNT_W-1:0]   w_spec_n  [ENTRIES];
    logic [IDX_W-1:0]   w_ptr_n;

    logic               w_hitF;
    logic               w_hitEX;
    logic               w_anyFree;
    logic [IDX_W-1:0]   w_idxF;
    logic [IDX_W-1:0]   w_idxEX;
    logic [IDX_W-1:0]   w_freeIdx;
    logic [IDX_W-1:0]   w_allocIdx;
    logic               w_exUpd;
    logic               w_unused;

    assign w_unused = ^{PC_F[31:14], PC_F[1:0], PC_EX[31:14], PC_EX[1:0]};

    // Descending scan so the lowest-numbered invalid entry is chosen for allocation.
    always_comb begin
        w_hitF    = 1'b0;
        w_idxF    = '0;
        w_hitEX   = 1'b0;
        w_idxEX   = '0;
        w_anyFree = 1'b0;
        w_freeIdx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == PC_F[13:2])) begin
                w_hitF = 1'b1;
                w_idxF = IDX_W'(i);
            end
            if (r_valid[i] && (r_tag[i] == PC_EX[13:2])) begin
                w_hitEX = 1'b1;
                w_idxEX = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_anyFree = 1'b1;
                w_freeIdx = IDX_W'(i);
            end
        end
    end

    assign LD_hit_F      = branch_en_F & backward_F & w_hitF & (r_state[w_idxF] == LOCKED);
    assign LD_decision_F = LD_hit_F & (r_spec[w_idxF] < r_trip[w_idxF]);
    assign w_exUpd       = branch_en_EX & backward_EX;
    assign w_allocIdx    = w_anyFree ? w_freeIdx : r_ptr;

    // Write order sets priority: fetch spec update, then EX fields, then correction reload.
    always_comb begin
        w_valid_n = r_valid;
        w_ptr_n   = r_ptr;
        for (int i = 0; i < ENTRIES; i++) begin
            w_tag_n[i]   = r_tag[i];
            w_state_n[i] = r_state[i];
            w_trip_n[i]  = r_trip[i];
            w_cur_n[i]   = r_cur[i];
            w_spec_n[i]  = r_spec[i];
        end

        if (LD_hit_F && !stall_F) begin
            w_spec_n[w_idxF] = LD_decision_F ? (r_spec[w_idxF] + 1'b1) : '0;
        end

        if (w_exUpd) begin
            if (branch_result && !w_hitEX) begin
                w_valid_n[w_allocIdx] = 1'b1;
                w_tag_n[w_allocIdx]   = PC_EX[13:2];
                w_state_n[w_allocIdx] = TRAIN;
                w_cur_n[w_allocIdx]   = CNT_W'(1);
                w_spec_n[w_allocIdx]  = '0;
                w_ptr_n               = r_ptr + 1'b1;
            end else if (branch_result) begin
                if (&r_cur[w_idxEX]) begin
                    w_valid_n[w_idxEX] = 1'b0;
                end else begin
                    w_cur_n[w_idxEX] = r_cur[w_idxEX] + 1'b1;
                end
            end else if (w_hitEX) begin
                case (r_state[w_idxEX])
                    TRAIN: begin
                        w_trip_n[w_idxEX]  = r_cur[w_idxEX];
                        w_state_n[w_idxEX] = RETRAIN;
                    end
                    CONFIRM: begin
                        if (r_cur[w_idxEX] == r_trip[w_idxEX]) begin
                            w_state_n[w_idxEX] = LOCKED;
                        end else begin
                            w_trip_n[w_idxEX] = r_cur[w_idxEX];
                        end
                    end
                    LOCKED: begin
                        if (r_cur[w_idxEX] != r_trip[w_idxEX]) begin
                            w_trip_n[w_idxEX]  = r_cur[w_idxEX];
                            w_state_n[w_idxEX] = RETRAIN;
                        end
                    end
                    default: begin
                        w_state_n[w_idxEX] = TRAIN;
                    end
                endcase
                w_cur_n[w_idxEX] = '0;
            end
        end

        if (branch_correction) begin
            for (int i = 0; i < ENTRIES; i++) begin
                w_spec_n[i] = w_cur_n[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_ptr   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]   <= '0;
                r_state[i] <= TRAIN;
                r_trip[i]  <= '0;
                r_cur[i]   <= '0;
                r_spec[i]  <= '0;
            end
        end else begin
            r_valid <= w_valid_n;
            r_ptr   <= w_ptr_n;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]   <= w_tag_n[i];
                r_state[i] <= w_state_n[i];
                r_trip[i]  <= w_trip_n[i];
                r_cur[i]   <= w_cur_n[i];
                r_spec[i]  <= w_spec_n[i];
            end
        end
    end

endmodule
